uc_multiciclo: RTL and testbench
================================

Name: uc_multiciclo

Overview:
- Multicycle control unit that drives the `fd` datapath. It decodes `opcode`/`funct3`/`funct7` and sequences each instruction through fetch/decode/execute/memory/writeback.
- Generates every datapath control strobe (`alu_cmd`, `alu_src`, `pc_src`, `rf_src`, `rf_we`, `d_mem_we`) plus the instruction-register and PC load enables.
- Supported subset: add, sub, and, or, addi, ld, sd, beq, bne. Any other encoding stops the core in HALT.

Parameters:
- `MEM_LAT`, 1, number of cycles the data memory needs per access; legal range 1..15.
- `CNT_W`, 4, width of the memory wait counter; must satisfy 2^`CNT_W` > `MEM_LAT`.

Ports:
- `clk`  in  1  core clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous reset, active-high. The name matches the datapath port; the polarity is high.
- `opcode`  in  7  instr[6:0] from the datapath.
- `funct3`  in  3  instr[14:12].
- `funct7`  in  7  instr[31:25].
- `alu_flags`  in  4  bit0 zero, bit1 MSB, bit2 overflow, bit3 unused.
- `ir_we`  out  1  load the instruction register from `i_mem_data`.
- `pc_we`  out  1  update the PC.
- `pc_src`  out  1  0: PC+4; 1: PC+imm (branch target).
- `alu_src`  out  1  0: ALU B operand = rs2; 1: ALU B operand = immediate.
- `rf_src`  out  1  0: write ALU result to RF; 1: write `d_mem_data` to RF.
- `rf_we`  out  1  register file write enable.
- `d_mem_we`  out  1  data memory write enable.
- `alu_cmd`  out  4  0000 ADD, 0001 SUB, 0010 AND, 0011 OR; other codes never driven.
- `halt`  out  1  illegal instruction seen; core stopped.

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT. Outputs are Moore, decoded from the state and the latched class `cls`.
- Reset: when `rst_n`=1 at an edge, state←IDLE, `cls`←ILL, counter←0.
  - In IDLE all outputs are 0, including `halt`.
  - IDLE→FETCH unconditionally on the next edge.
  - Reset has priority in every state, including mid-MEM wait and HALT.
- FETCH: `ir_we`=1 for one cycle; →DECODE.
- DECODE: all strobes 0. Latch `cls` from `opcode`/`funct3`/`funct7`:
  - 0110011 with `funct7` 0000000 and `funct3` 000/111/110 → R_ADD/R_AND/R_OR.
  - 0110011 with `funct7` 0100000 and `funct3` 000 → R_SUB.
  - 0010011 with `funct3` 000 → ADDI.
  - 0000011 with `funct3` 011 → LD.
  - 0100011 with `funct3` 011 → SD.
  - 1100011 with `funct3` 000 → BEQ; with `funct3` 001 → BNE.
  - Anything else → ILL.
  - Next state: ILL→HALT; otherwise →EXEC.
- EXEC:
  - R_*: `alu_src`=0; `alu_cmd` per class.
  - ADDI/LD/SD: `alu_src`=1, `alu_cmd`=ADD.
  - BEQ/BNE: `alu_src`=0, `alu_cmd`=SUB, `pc_we`=1, `pc_src`=taken.
    - BEQ taken = `alu_flags`[0]=1; BNE taken = `alu_flags`[0]=0.
    - Next state FETCH.
  - R_*/ADDI→WB. LD/SD→MEM, counter←0.
- MEM:
  - `alu_src`=1 and `alu_cmd`=ADD are held so the address stays stable. SD: `d_mem_we`=1 for every MEM cycle.
  - Counter increments each cycle. Exit when counter = `MEM_LAT`-1, so MEM lasts exactly `MEM_LAT` cycles.
  - On the exit cycle: LD→WB; SD asserts `pc_we`=1 with `pc_src`=0 and →FETCH.
- WB:
  - `rf_we`=1 and `pc_we`=1 with `pc_src`=0. `rf_src`=1 for LD, 0 otherwise.
  - `alu_src`/`alu_cmd` are held from EXEC. →FETCH.
- HALT: all strobes 0, `halt`=1. The unit stays in HALT until reset.
- Latency per instruction, counted from the FETCH cycle: R/ADDI 4; branch 3; LD 4+`MEM_LAT`; SD 3+`MEM_LAT`.
- `pc_we`=1 occurs exactly once per instruction.
- `rf_we` and `d_mem_we` are never both 1.
- `ir_we`=1 only in FETCH.
- Unspecified outputs in every state are 0.

Decomposition:
- Package `uc_pkg`:
  - State enum.
  - Class enum: R_ADD, R_SUB, R_AND, R_OR, ADDI, LD, SD, BEQ, BNE, ILL.
  - `alu_cmd` code constants.
  - Opcode constants OP_R=0110011, OP_IMM=0010011, OP_LD=0000011, OP_ST=0100011, OP_BR=1100011.
  - Flag bit indices.
- One sub-module, `uc_decoder`: combinational `opcode`/`funct3`/`funct7` → class. The FSM, counter and output decode stay in `uc_multiciclo`.

Test Plan:
- Reset held 3 cycles then released → all outputs 0 during reset and IDLE; `ir_we`=1 exactly on the 2nd cycle after release.
- opcode=0110011, funct7=0100000, funct3=000 (sub) → EXEC `alu_cmd`=0001, `alu_src`=0; WB `rf_we`=1, `rf_src`=0, `pc_we`=1; next `ir_we` 4 cycles after the previous one.
- `MEM_LAT`=3, ld (0000011/011) → MEM lasts 3 cycles with `d_mem_we`=0; WB `rf_src`=1, `rf_we`=1; total 7 cycles. sd (0100011/011) → `d_mem_we`=1 for 3 cycles, `pc_we` only on the last; total 6 cycles.
- beq with `alu_flags`=0001 → EXEC `pc_we`=1, `pc_src`=1. bne with `alu_flags`=0001 → `pc_src`=0. Both take 3 cycles and never assert `rf_we`.
- opcode=1101111 (jal, unsupported) → DECODE→HALT, `halt`=1 held for 20 cycles with all strobes 0. Asserting reset then releasing → `halt`=0 and the FETCH cycle occurs.
- `rst_n` asserted in the 2nd MEM cycle of sd with `MEM_LAT`=3 → `d_mem_we`=0 on the next cycle, state IDLE, no `pc_we` pulse.

Source files
------------

// File: rtl/uc_pkg.sv
// Shared types and constants for the multicycle control unit.
// Holds the FSM state enum, the decoded instruction class enum, ALU command codes,
// RV opcode/funct constants and the ALU flag bit positions.
package uc_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StHalt
  } state_e;

  typedef enum logic [3:0] {
    ClsRAdd,
    ClsRSub,
    ClsRAnd,
    ClsROr,
    ClsAddi,
    ClsLd,
    ClsSd,
    ClsBeq,
    ClsBne,
    ClsIll
  } cls_e;

  // ALU command codes understood by the datapath
  localparam logic [3:0] AluAdd = 4'b0000;
  localparam logic [3:0] AluSub = 4'b0001;
  localparam logic [3:0] AluAnd = 4'b0010;
  localparam logic [3:0] AluOr  = 4'b0011;

  // Major opcodes
  localparam logic [6:0] OpR   = 7'b0110011;
  localparam logic [6:0] OpImm = 7'b0010011;
  localparam logic [6:0] OpLd  = 7'b0000011;
  localparam logic [6:0] OpSt  = 7'b0100011;
  localparam logic [6:0] OpBr  = 7'b1100011;

  // funct3 / funct7 selectors
  localparam logic [2:0] F3AddSub = 3'b000;
  localparam logic [2:0] F3And    = 3'b111;
  localparam logic [2:0] F3Or     = 3'b110;
  localparam logic [2:0] F3Addi   = 3'b000;
  localparam logic [2:0] F3Dword  = 3'b011;
  localparam logic [2:0] F3Beq    = 3'b000;
  localparam logic [2:0] F3Bne    = 3'b001;
  localparam logic [6:0] F7Base   = 7'b0000000;
  localparam logic [6:0] F7Alt    = 7'b0100000;

  // alu_flags bit positions (bit 3 is unused)
  localparam int unsigned FlagZero = 0;
  localparam int unsigned FlagMsb  = 1;
  localparam int unsigned FlagOvf  = 2;

  // ALU operation a class uses for its arithmetic (address or result)
  function automatic logic [3:0] cls_alu_cmd(input cls_e cls);
    logic [3:0] cmd;
    case (cls)
      ClsRSub: cmd = AluSub;
      ClsRAnd: cmd = AluAnd;
      ClsROr:  cmd = AluOr;
      default: cmd = AluAdd;
    endcase
    return cmd;
  endfunction

  // Register-register classes take ALU operand B from rs2
  function automatic logic cls_is_r(input cls_e cls);
    return (cls == ClsRAdd) || (cls == ClsRSub) || (cls == ClsRAnd) || (cls == ClsROr);
  endfunction

endpackage

// File: rtl/uc_decoder.sv
// Combinational instruction classifier.
// Ports:
//   i_opcode  instr[6:0]
//   i_funct3  instr[14:12]
//   i_funct7  instr[31:25]
//   o_cls     decoded class; ClsIll for anything outside the supported subset
module uc_decoder
  import uc_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic [6:0] i_funct7,
  output cls_e       o_cls
);

  always_comb begin
    o_cls = ClsIll;
    case (i_opcode)
      OpR: begin
        if (i_funct7 == F7Base) begin
          case (i_funct3)
            F3AddSub: o_cls = ClsRAdd;
            F3And:    o_cls = ClsRAnd;
            F3Or:     o_cls = ClsROr;
            default:  o_cls = ClsIll;
          endcase
        end else if (i_funct7 == F7Alt && i_funct3 == F3AddSub) begin
          o_cls = ClsRSub;
        end
      end
      OpImm: if (i_funct3 == F3Addi)  o_cls = ClsAddi;
      OpLd:  if (i_funct3 == F3Dword) o_cls = ClsLd;
      OpSt:  if (i_funct3 == F3Dword) o_cls = ClsSd;
      OpBr: begin
        if (i_funct3 == F3Beq)      o_cls = ClsBeq;
        else if (i_funct3 == F3Bne) o_cls = ClsBne;
      end
      default: o_cls = ClsIll;
    endcase
  end

endmodule

// File: rtl/uc_multiciclo.sv
// Multicycle control unit for the fd datapath.
// Sequences each instruction through FETCH/DECODE/EXEC/[MEM]/[WB] and decodes the
// datapath strobes from the current state and the class latched in DECODE.
// Ports:
//   i_clk        core clock, rising edge
//   i_rst_n      synchronous reset, ACTIVE HIGH (name kept to match the datapath)
//   i_opcode     instr[6:0]; i_funct3 instr[14:12]; i_funct7 instr[31:25]
//   i_alu_flags  bit0 zero, bit1 MSB, bit2 overflow, bit3 unused
//   o_ir_we      load IR           o_pc_we   update PC      o_pc_src  0 PC+4, 1 PC+imm
//   o_alu_src    0 rs2, 1 imm      o_rf_src  0 ALU, 1 mem   o_rf_we   RF write
//   o_d_mem_we   data mem write    o_alu_cmd ALU operation  o_halt    illegal instr seen
module uc_multiciclo
  import uc_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned CNT_W   = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic [6:0] i_funct7,
  input  logic [3:0] i_alu_flags,
  output logic       o_ir_we,
  output logic       o_pc_we,
  output logic       o_pc_src,
  output logic       o_alu_src,
  output logic       o_rf_src,
  output logic       o_rf_we,
  output logic       o_d_mem_we,
  output logic [3:0] o_alu_cmd,
  output logic       o_halt
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(MEM_LAT - 1);

  state_e           r_state;
  cls_e             r_cls;
  logic [CNT_W-1:0] r_cnt;
  cls_e             w_cls;
  logic             w_mem_last;
  logic             w_taken;
  logic             w_unused_flags;

  uc_decoder u_decoder (
    .i_opcode (i_opcode),
    .i_funct3 (i_funct3),
    .i_funct7 (i_funct7),
    .o_cls    (w_cls)
  );

  assign w_mem_last = (r_cnt == CntLast);
  // BEQ branches on zero, BNE on non-zero
  assign w_taken    = (r_cls == ClsBeq) ? i_alu_flags[FlagZero] : ~i_alu_flags[FlagZero];
  assign w_unused_flags = i_alu_flags[FlagMsb] ^ i_alu_flags[FlagOvf] ^ i_alu_flags[3];

  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      r_state <= StIdle;
      r_cls   <= ClsIll;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        StIdle:   r_state <= StFetch;
        StFetch:  r_state <= StDecode;
        StDecode: begin
          r_cls   <= w_cls;
          r_state <= (w_cls == ClsIll) ? StHalt : StExec;
        end
        StExec: begin
          case (r_cls)
            ClsBeq, ClsBne: r_state <= StFetch;
            ClsLd, ClsSd: begin
              r_state <= StMem;
              r_cnt   <= '0;
            end
            default: r_state <= StWb;
          endcase
        end
        StMem: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_mem_last) begin
            r_state <= (r_cls == ClsLd) ? StWb : StFetch;
          end
        end
        StWb:    r_state <= StFetch;
        StHalt:  r_state <= StHalt;
        default: r_state <= StIdle;
      endcase
    end
  end

  // Moore decode; only the branch target select looks at the live ALU flags.
  always_comb begin
    o_ir_we    = 1'b0;
    o_pc_we    = 1'b0;
    o_pc_src   = 1'b0;
    o_alu_src  = 1'b0;
    o_rf_src   = 1'b0;
    o_rf_we    = 1'b0;
    o_d_mem_we = 1'b0;
    o_alu_cmd  = AluAdd;
    o_halt     = 1'b0;
    case (r_state)
      StFetch: o_ir_we = 1'b1;
      StExec: begin
        if (r_cls == ClsBeq || r_cls == ClsBne) begin
          o_alu_cmd = AluSub;
          o_pc_we   = 1'b1;
          o_pc_src  = w_taken;
        end else begin
          o_alu_src = ~cls_is_r(r_cls);
          o_alu_cmd = cls_alu_cmd(r_cls);
        end
      end
      StMem: begin
        // Address operands held so the memory sees a stable address
        o_alu_src  = 1'b1;
        o_alu_cmd  = AluAdd;
        o_d_mem_we = (r_cls == ClsSd);
        o_pc_we    = (r_cls == ClsSd) && w_mem_last;
      end
      StWb: begin
        o_rf_we   = 1'b1;
        o_pc_we   = 1'b1;
        o_rf_src  = (r_cls == ClsLd);
        o_alu_src = ~cls_is_r(r_cls);
        o_alu_cmd = cls_alu_cmd(r_cls);
      end
      StHalt:  o_halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uc_multiciclo.sv
// Randomised self-checking bench for uc_multiciclo (MEM_LAT = 3).
// Each instruction is turned into its expected per-cycle output trace from the
// instruction-level rules; a single negedge process compares DUT outputs against it.
module tb_uc_multiciclo;

  localparam int MemLat = 3;

  typedef logic [11:0] vec_t;
  // Trace word layout: ir pcwe pcsrc asrc rfsrc rfwe dwe cmd[3:0] halt
  localparam vec_t BIr    = 12'h800;
  localparam vec_t BPcWe  = 12'h400;
  localparam vec_t BPcSrc = 12'h200;
  localparam vec_t BASrc  = 12'h100;
  localparam vec_t BRfSrc = 12'h080;
  localparam vec_t BRfWe  = 12'h040;
  localparam vec_t BDWe   = 12'h020;
  localparam vec_t BHalt  = 12'h001;

  localparam int CRAdd = 0, CRSub = 1, CRAnd = 2, CROr = 3, CAddi = 4;
  localparam int CLd = 5, CSd = 6, CBeq = 7, CBne = 8, CIll = 9;

  logic       clk;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [3:0] alu_flags;
  logic       ir_we, pc_we, pc_src, alu_src, rf_src, rf_we, d_mem_we, halt;
  logic [3:0] alu_cmd;

  int    n_cmp;
  int    n_mis;
  int    cyc;
  vec_t  exp_q[$];
  string tag_q[$];
  vec_t  tr_q[$];
  vec_t  got;

  uc_multiciclo #(
    .MEM_LAT (MemLat),
    .CNT_W   (4)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_opcode    (opcode),
    .i_funct3    (funct3),
    .i_funct7    (funct7),
    .i_alu_flags (alu_flags),
    .o_ir_we     (ir_we),
    .o_pc_we     (pc_we),
    .o_pc_src    (pc_src),
    .o_alu_src   (alu_src),
    .o_rf_src    (rf_src),
    .o_rf_we     (rf_we),
    .o_d_mem_we  (d_mem_we),
    .o_alu_cmd   (alu_cmd),
    .o_halt      (halt)
  );

  assign got = {ir_we, pc_we, pc_src, alu_src, rf_src, rf_we, d_mem_we, alu_cmd, halt};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t cmdv(input int c);
    return vec_t'(c) << 1;
  endfunction

  function automatic int classify(input logic [6:0] op, input logic [2:0] f3,
                                  input logic [6:0] f7);
    if (op == 7'b0110011 && f7 == 7'b0000000 && f3 == 3'b000) return CRAdd;
    if (op == 7'b0110011 && f7 == 7'b0000000 && f3 == 3'b111) return CRAnd;
    if (op == 7'b0110011 && f7 == 7'b0000000 && f3 == 3'b110) return CROr;
    if (op == 7'b0110011 && f7 == 7'b0100000 && f3 == 3'b000) return CRSub;
    if (op == 7'b0010011 && f3 == 3'b000) return CAddi;
    if (op == 7'b0000011 && f3 == 3'b011) return CLd;
    if (op == 7'b0100011 && f3 == 3'b011) return CSd;
    if (op == 7'b1100011 && f3 == 3'b000) return CBeq;
    if (op == 7'b1100011 && f3 == 3'b001) return CBne;
    return CIll;
  endfunction

  // Expected output trace of one instruction, starting with its FETCH cycle
  function automatic void build(input int cls, input logic [3:0] flags);
    int   cmd;
    logic taken;
    tr_q.delete();
    tr_q.push_back(BIr);
    tr_q.push_back('0);
    case (cls)
      CRAdd, CRSub, CRAnd, CROr: begin
        cmd = (cls == CRAdd) ? 0 : (cls == CRSub) ? 1 : (cls == CRAnd) ? 2 : 3;
        tr_q.push_back(cmdv(cmd));
        tr_q.push_back(BRfWe | BPcWe | cmdv(cmd));
      end
      CAddi: begin
        tr_q.push_back(BASrc);
        tr_q.push_back(BRfWe | BPcWe | BASrc);
      end
      CBeq, CBne: begin
        taken = (cls == CBeq) ? flags[0] : !flags[0];
        tr_q.push_back(BPcWe | (taken ? BPcSrc : vec_t'(0)) | cmdv(1));
      end
      CLd: begin
        tr_q.push_back(BASrc);
        for (int i = 0; i < MemLat; i++) tr_q.push_back(BASrc);
        tr_q.push_back(BRfWe | BRfSrc | BPcWe | BASrc);
      end
      CSd: begin
        tr_q.push_back(BASrc);
        for (int i = 0; i < MemLat; i++)
          tr_q.push_back(BASrc | BDWe | ((i == MemLat - 1) ? BPcWe : vec_t'(0)));
      end
      default: begin
        for (int i = 0; i < 20; i++) tr_q.push_back(BHalt);
      end
    endcase
  endfunction

  task automatic pin(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_mis++;
      $display("FAIL model %s got=%0h expected=%0h", name, act, req);
    end
  endtask

  // Entered and left at posedge+1 of a FETCH cycle. cut>0 truncates the trace and
  // asserts reset during its last cycle; illegal instructions are reset after 20 HALT cycles.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [3:0] fl, input int cut, input string name);
    int cls;
    cls       = classify(op, f3, f7);
    opcode    = op;
    funct3    = f3;
    funct7    = f7;
    alu_flags = fl;
    build(cls, fl);
    if (cut > 0) while (tr_q.size() > cut) void'(tr_q.pop_back());
    foreach (tr_q[i]) begin
      exp_q.push_back(tr_q[i]);
      tag_q.push_back(name);
    end
    repeat (tr_q.size() - 1) @(posedge clk);
    #1;
    if (cls == CIll || cut > 0) begin
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      exp_q.push_back('0);
      tag_q.push_back({name, "_idle"});
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    vec_t  e;
    string t;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_mis++;
        $display("FAIL %s cycle %0d outputs got=%03h expected=%03h", t, cyc, got, e);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] t_op[9];
    logic [2:0] t_f3[9];
    logic [6:0] t_f7[9];
    logic [6:0] op, f7;
    logic [2:0] f3;
    int         sel;
    t_op = '{7'b0110011, 7'b0110011, 7'b0110011, 7'b0110011, 7'b0010011,
             7'b0000011, 7'b0100011, 7'b1100011, 7'b1100011};
    t_f3 = '{3'b000, 3'b000, 3'b111, 3'b110, 3'b000, 3'b011, 3'b011, 3'b000, 3'b001};
    t_f7 = '{7'b0000000, 7'b0100000, 7'b0000000, 7'b0000000, 7'b0, 7'b0, 7'b0, 7'b0, 7'b0};
    n_cmp = 0;
    n_mis = 0;
    cyc   = 0;
    rst_n = 1'b1;
    opcode = '0;
    funct3 = '0;
    funct7 = '0;
    alu_flags = '0;

    // Hand-computed values pinning the trace model
    build(CRSub, 4'b0000);
    pin("sub_len", tr_q.size(), 4);
    pin("sub_fetch", tr_q[0], 12'h800);
    pin("sub_exec", tr_q[2], 12'h002);
    pin("sub_wb", tr_q[3], 12'h442);
    build(CLd, 4'b0000);
    pin("ld_len", tr_q.size(), 7);
    pin("ld_wb", tr_q[6], 12'h5C0);
    build(CSd, 4'b0000);
    pin("sd_len", tr_q.size(), 6);
    pin("sd_mem2", tr_q[4], 12'h120);
    pin("sd_mem3", tr_q[5], 12'h520);
    build(CBeq, 4'b0001);
    pin("beq_len", tr_q.size(), 3);
    pin("beq_exec", tr_q[2], 12'h602);
    build(CBne, 4'b0001);
    pin("bne_exec", tr_q[2], 12'h402);
    pin("jal_class", classify(7'b1101111, 3'b000, 7'b0), CIll);

    // Reset held for three edges, then one IDLE cycle before FETCH
    @(posedge clk);
    #1;
    repeat (2) begin
      exp_q.push_back('0);
      tag_q.push_back("reset");
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.push_back('0);
    tag_q.push_back("idle");
    @(posedge clk);
    #1;

    run_instr(7'b0110011, 3'b000, 7'b0100000, 4'b0000, 0, "sub");
    run_instr(7'b0000011, 3'b011, 7'b0000000, 4'b0000, 0, "ld");
    run_instr(7'b0100011, 3'b011, 7'b0000000, 4'b0000, 0, "sd");
    run_instr(7'b1100011, 3'b000, 7'b0000000, 4'b0001, 0, "beq_taken");
    run_instr(7'b1100011, 3'b001, 7'b0000000, 4'b0001, 0, "bne_not_taken");
    run_instr(7'b1100011, 3'b000, 7'b0000000, 4'b0000, 0, "beq_not_taken");
    run_instr(7'b1100011, 3'b001, 7'b0000000, 4'b0100, 0, "bne_taken");
    run_instr(7'b0110011, 3'b000, 7'b0000000, 4'b0000, 0, "add");
    run_instr(7'b0110011, 3'b111, 7'b0000000, 4'b0000, 0, "and");
    run_instr(7'b0110011, 3'b110, 7'b0000000, 4'b0000, 0, "or");
    run_instr(7'b0010011, 3'b000, 7'b1010101, 4'b0000, 0, "addi");
    run_instr(7'b0110011, 3'b001, 7'b0000000, 4'b0000, 0, "sll_illegal");
    run_instr(7'b0100011, 3'b011, 7'b0000000, 4'b0000, 5, "sd_reset_mem2");
    run_instr(7'b1101111, 3'b000, 7'b0000000, 4'b0000, 0, "jal_halt");
    run_instr(7'b0110011, 3'b000, 7'b0100000, 4'b0000, 0, "sub_after_halt");

    for (int k = 0; k < 150; k++) begin
      sel = $urandom_range(0, 11);
      if (sel < 9) begin
        op = t_op[sel];
        f3 = t_f3[sel];
        f7 = (sel < 4) ? t_f7[sel] : 7'($urandom);
      end else begin
        op = 7'($urandom);
        f3 = 3'($urandom);
        f7 = 7'($urandom);
      end
      run_instr(op, f3, f7, 4'($urandom), 0, "rand");
    end

    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_mis++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
